// File: rtl/inv_shift_rows_stream.sv
// Byte-serial AES InvShiftRows: buffers 16-byte blocks and replays them in permuted order.
// Optional macro ISR_FWD_MODE_EN adds a per-block mode input selecting forward ShiftRows order.
module inv_shift_rows_stream #(
    parameter int unsigned NUM_BUF = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic [7:0] s_data,
    input  logic       s_last,
`ifdef ISR_FWD_MODE_EN
    input  logic       mode,
`endif
    output logic       m_valid,
    input  logic       m_ready,
    output logic [7:0] m_data,
    output logic       m_last,
    output logic       err
);

    localparam int unsigned BW    = 8;
    localparam int unsigned CW    = 4;
    localparam int unsigned BEATS = 16;

    logic [BW-1:0]      mem [NUM_BUF][BEATS];
    logic [NUM_BUF-1:0] full, full_n;
    logic [CW-1:0]      wr_cnt, wr_cnt_n, rd_cnt, rd_cnt_n;
    logic               wr_sel, wr_sel_n, rd_sel, rd_sel_n;
    logic               s_ready_n, m_valid_n, m_last_n, err_n;
    logic [BW-1:0]      m_data_n;
    logic               wr_fire, wr_done, rd_avail, rd_load;
    logic [1:0]         row, col;
    logic [CW-1:0]      rd_idx;

    assign wr_fire = s_valid && s_ready;
    assign wr_done = wr_fire && (wr_cnt == CW'(BEATS - 1));
    // A block completing this cycle may be read immediately: byte P(0)=0 is already stored.
    assign rd_avail = full[rd_sel] || (wr_done && (wr_sel == rd_sel));
    assign rd_load  = (!m_valid || m_ready) && rd_avail;

    assign row = rd_cnt[1:0];
    assign col = rd_cnt[3:2];

`ifdef ISR_FWD_MODE_EN
    logic mode_buf [NUM_BUF];

    always_ff @(posedge clk) begin
        if (wr_fire && (wr_cnt == '0))
            mode_buf[wr_sel] <= mode;
    end

    assign rd_idx = mode_buf[rd_sel] ? {2'(col + row), row} : {2'(col - row), row};
`else
    assign rd_idx = {2'(col - row), row};
`endif

    // Block storage carries no reset; validity is tracked by the full flags.
    always_ff @(posedge clk) begin
        if (wr_fire)
            mem[wr_sel][wr_cnt] <= s_data;
    end

    always_comb begin
        full_n    = full;
        wr_cnt_n  = wr_cnt;
        rd_cnt_n  = rd_cnt;
        wr_sel_n  = wr_sel;
        rd_sel_n  = rd_sel;
        m_valid_n = m_valid;
        m_data_n  = m_data;
        m_last_n  = m_last;
        err_n     = 1'b0;

        if (rd_load) begin
            m_valid_n = 1'b1;
            m_data_n  = mem[rd_sel][rd_idx];
            m_last_n  = (rd_cnt == CW'(BEATS - 1));
            if (rd_cnt == CW'(BEATS - 1)) begin
                full_n[rd_sel] = 1'b0;
                rd_cnt_n       = '0;
                rd_sel_n       = (NUM_BUF == 2) ? !rd_sel : 1'b0;
            end else begin
                rd_cnt_n = rd_cnt + CW'(1);
            end
        end else if (m_valid && m_ready) begin
            m_valid_n = 1'b0;
        end

        if (wr_fire) begin
            if (wr_cnt == CW'(BEATS - 1)) begin
                full_n[wr_sel] = 1'b1;
                wr_cnt_n       = '0;
                wr_sel_n       = (NUM_BUF == 2) ? !wr_sel : 1'b0;
                err_n          = !s_last;
            end else if (s_last) begin
                // Early s_last: drop the partial block and restart the buffer.
                wr_cnt_n = '0;
                err_n    = 1'b1;
            end else begin
                wr_cnt_n = wr_cnt + CW'(1);
            end
        end

        s_ready_n = !full_n[wr_sel_n];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full    <= '0;
            wr_cnt  <= '0;
            rd_cnt  <= '0;
            wr_sel  <= 1'b0;
            rd_sel  <= 1'b0;
            s_ready <= 1'b0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_last  <= 1'b0;
            err     <= 1'b0;
        end else begin
            full    <= full_n;
            wr_cnt  <= wr_cnt_n;
            rd_cnt  <= rd_cnt_n;
            wr_sel  <= wr_sel_n;
            rd_sel  <= rd_sel_n;
            s_ready <= s_ready_n;
            m_valid <= m_valid_n;
            m_data  <= m_data_n;
            m_last  <= m_last_n;
            err     <= err_n;
        end
    end

endmodule

// File: tb/tb_inv_shift_rows_stream.sv
// Directed self-checking bench for inv_shift_rows_stream (NUM_BUF=2).
module tb_inv_shift_rows_stream;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [7:0] s_data = 8'h00;
    logic       s_last = 1'b0;
`ifdef ISR_FWD_MODE_EN
    logic       mode = 1'b0;
`endif
    logic       m_valid;
    logic       m_ready = 1'b1;
    logic [7:0] m_data;
    logic       m_last;
    logic       err;

    inv_shift_rows_stream #(.NUM_BUF(2)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_last  (s_last),
`ifdef ISR_FWD_MODE_EN
        .mode    (mode),
`endif
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_last  (m_last),
        .err     (err)
    );

    always #5 clk = ~clk;

    logic [7:0] ip [16] = '{8'h0, 8'hD, 8'hA, 8'h7, 8'h4, 8'h1, 8'hE, 8'hB,
                            8'h8, 8'h5, 8'h2, 8'hF, 8'hC, 8'h9, 8'h6, 8'h3};
    logic [7:0] fp [16] = '{8'h0, 8'h5, 8'hA, 8'hF, 8'h4, 8'h9, 8'hE, 8'h3,
                            8'h8, 8'hD, 8'h2, 8'h7, 8'hC, 8'h1, 8'h6, 8'hB};
    logic       pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    int         total = 0;
    int         bad = 0;
    int         out_beats = 0;
    int         stalls = 0;
    int         pc = 0;
    bit         stall_en = 1'b0;
    logic [7:0] exp_q [$];
    bit         exp_l [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One clock; retire a transferred beat and check the presented beat against the queue head.
    task automatic tick();
        bit         of;
        logic [7:0] d;
        bit         l;
        of = m_valid && m_ready;
        @(posedge clk);
        #1;
        if (of) begin
            out_beats++;
            if (exp_q.size() > 0) begin
                d = exp_q.pop_front();
                l = exp_l.pop_front();
            end
        end
        if (m_valid) begin
            total++;
            assert (exp_q.size() > 0) else begin
                bad++;
                $error("FAIL unexpected_beat: observed %0h expected none", m_data);
            end
            if (exp_q.size() > 0) begin
                chk("m_data", m_data, exp_q[0]);
                chk("m_last", m_last, exp_l[0]);
            end
        end
        if (stall_en) begin
            m_ready = pat[pc % 4];
            pc++;
        end
    endtask

    task automatic send_block(input logic [7:0] base, input int last_pos, input int nbeats,
                              input int npush, input bit fwd);
        int n;
        bit acc;
        bit exp_err;
        for (int k = 0; k < npush; k++) begin
            exp_q.push_back(base | (fwd ? fp[k] : ip[k]));
            exp_l.push_back(k == 15);
        end
        for (int k = 0; k < nbeats; k++) begin
            s_valid = 1'b1;
            s_data  = base | 8'(k);
            s_last  = (k == last_pos);
`ifdef ISR_FWD_MODE_EN
            mode    = fwd;
`endif
            n = 0;
            do begin
                acc = s_ready;
                tick();
                n++;
            end while (!acc && n < 200);
            chk("accept_timeout", 32'(acc), 32'd1);
            if (n > 1) stalls++;
            exp_err = ((k == last_pos) && (k < 15)) || ((k == 15) && (last_pos != 15));
            chk("err", 32'(err), 32'(exp_err));
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 500) begin
            tick();
            n++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int ob0;

        // Reset state
        #12;
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        chk("rst_m_last", 32'(m_last), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("s_ready_after_release", 32'(s_ready), 32'd1);

        // Single block and first-beat latency
        send_block(8'h00, 15, 16, 16, 1'b0);
        chk("latency_m_valid", 32'(m_valid), 32'd1);
        drain();

        // Two back-to-back blocks: no input stall, no output bubble
        stalls = 0;
        ob0 = out_beats;
        send_block(8'h00, 15, 16, 16, 1'b0);
        send_block(8'h10, 15, 16, 16, 1'b0);
        for (int i = 0; i < 16; i++) tick();
        chk("no_bubble_beats", 32'(out_beats - ob0), 32'd32);
        chk("no_input_stall", 32'(stalls), 32'd0);
        drain();

        // Downstream backpressure; third block must stall on full buffers
        stall_en = 1'b1;
        stalls = 0;
        send_block(8'h20, 15, 16, 16, 1'b0);
        send_block(8'h30, 15, 16, 16, 1'b0);
        send_block(8'h40, 15, 16, 16, 1'b0);
        chk("third_block_stalls", 32'(stalls > 0), 32'd1);
        drain();
        stall_en = 1'b0;
        m_ready = 1'b1;
        tick();

        // Early s_last discards the partial block
        send_block(8'h50, 5, 6, 0, 1'b0);
        tick();
        chk("err_one_cycle", 32'(err), 32'd0);
        send_block(8'hA0, 15, 16, 16, 1'b0);
        drain();

        // Missing s_last on beat 15: err, block still emitted
        send_block(8'hB0, 16, 16, 16, 1'b0);
        drain();

        // Reset mid-operation
        m_ready = 1'b0;
        send_block(8'h60, 15, 16, 4, 1'b0);
        send_block(8'h70, 15, 8, 0, 1'b0);
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("pre_rst_head", 32'(m_data), 32'h67);
        rst_n = 1'b0;
        #1;
        chk("midrst_m_valid", 32'(m_valid), 32'd0);
        chk("midrst_m_data", 32'(m_data), 32'd0);
        chk("midrst_m_last", 32'(m_last), 32'd0);
        chk("midrst_s_ready", 32'(s_ready), 32'd0);
        exp_q.delete();
        exp_l.delete();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("post_rst_idle", 32'(m_valid), 32'd0);
        send_block(8'h80, 15, 16, 16, 1'b0);
        drain();

`ifdef ISR_FWD_MODE_EN
        send_block(8'h00, 15, 16, 16, 1'b1);
        send_block(8'hC0, 15, 16, 16, 1'b0);
        drain();
`endif

        for (int i = 0; i < 4; i++) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
